// File: rtl/sersub_pkg.sv
// rtl/sersub_pkg.sv - shared types and helpers for the bit-serial subtractor
//
// Contents:
//   state_t        FSM states: IDLE, SHIFT, FIN
//   cnt_width(w)   width of the bit counter for a w-bit operand ($clog2(w+1))
package sersub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  // Counter must represent 0..w so that it can step one past the last bit
  // index without wrapping.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/full_sub_cell.sv
// rtl/full_sub_cell.sv - combinational 1-bit full-subtractor cell
//
// Ports:
//   a    in   minuend bit
//   b    in   subtrahend bit
//   br   in   borrow-in
//   d    out  difference bit, a - b - br
//   brn  out  borrow-out
module full_sub_cell (
  input  logic a,
  input  logic b,
  input  logic br,
  output logic d,
  output logic brn
);

  assign d   = a ^ b ^ br;
  assign brn = (~a & b) | (~(a ^ b) & br);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial WIDTH-bit subtractor DIF = A - B - BR_IN
//
// One full_sub_cell is reused for WIDTH cycles, LSB first. Optional signed
// overflow output is enabled by defining SERSUB_SIGNED_OVF_EN.
//
// Ports:
//   CLK     in   clock, rising edge
//   RST     in   synchronous active-high reset
//   START   in   start request, sampled only in IDLE
//   A, B    in   minuend / subtrahend, captured on accepted START
//   BR_IN   in   borrow-in, captured on accepted START
//   BUSY    out  high while bits are processed (WIDTH cycles)
//   DONE    out  one-cycle pulse when DIF/BR_OUT become valid
//   DIF     out  registered difference
//   BR_OUT  out  registered borrow-out of the MSB
//   OVF     out  (SERSUB_SIGNED_OVF_EN only) two's-complement overflow
module serial_subtractor
  import sersub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BR_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] DIF,
  output logic             BR_OUT
`ifdef SERSUB_SIGNED_OVF_EN
  ,
  output logic             OVF
`endif
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dif_q, dif_d;
  logic             br_out_q, br_out_d;
`ifdef SERSUB_SIGNED_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             cell_d;
  logic             cell_brn;
  logic [WIDTH-1:0] sr_shift;

  full_sub_cell u_cell (
    .a   (sa_q[0]),
    .b   (sb_q[0]),
    .br  (br_q),
    .d   (cell_d),
    .brn (cell_brn)
  );

  // New difference bit enters at the MSB; after WIDTH shifts the LSB has
  // arrived at bit 0. Written with shifts so WIDTH=1 needs no special case.
  assign sr_shift = (sr_q >> 1) | (WIDTH'(cell_d) << (WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sr_d     = sr_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    dif_d    = dif_q;
    br_out_d = br_out_q;
`ifdef SERSUB_SIGNED_OVF_EN
    ovf_d    = ovf_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (START) begin
          sa_d    = A;
          sb_d    = B;
          br_d    = BR_IN;
          sr_d    = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        sr_d  = sr_shift;
        br_d  = cell_brn;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          dif_d    = sr_shift;
          br_out_d = cell_brn;
`ifdef SERSUB_SIGNED_OVF_EN
          // Borrow into the MSB differs from borrow out of it.
          ovf_d    = br_q ^ cell_brn;
`endif
          state_d  = FIN;
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      sr_q     <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      dif_q    <= '0;
      br_out_q <= 1'b0;
`ifdef SERSUB_SIGNED_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sr_q     <= sr_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      dif_q    <= dif_d;
      br_out_q <= br_out_d;
`ifdef SERSUB_SIGNED_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign BUSY   = (state_q == SHIFT);
  assign DONE   = (state_q == FIN);
  assign DIF    = dif_q;
  assign BR_OUT = br_out_q;
`ifdef SERSUB_SIGNED_OVF_EN
  assign OVF    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=1)
module tb_serial_subtractor;

  logic       clk = 1'b0;
  int         total = 0;
  int         bad = 0;

  logic       rst8, start8, bi8;
  logic [7:0] a8, b8;
  logic       busy8, done8, br8;
  logic [7:0] dif8;

  logic       rst1, start1, bi1;
  logic [0:0] a1, b1;
  logic       busy1, done1, br1;
  logic [0:0] dif1;

`ifdef SERSUB_SIGNED_OVF_EN
  logic       ovf8, ovf1;
`endif

  logic [7:0] last_dif;
  logic       last_br;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .CLK    (clk),
    .RST    (rst8),
    .START  (start8),
    .A      (a8),
    .B      (b8),
    .BR_IN  (bi8),
    .BUSY   (busy8),
    .DONE   (done8),
    .DIF    (dif8),
    .BR_OUT (br8)
`ifdef SERSUB_SIGNED_OVF_EN
    ,
    .OVF    (ovf8)
`endif
  );

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .CLK    (clk),
    .RST    (rst1),
    .START  (start1),
    .A      (a1),
    .B      (b1),
    .BR_IN  (bi1),
    .BUSY   (busy1),
    .DONE   (done1),
    .DIF    (dif1),
    .BR_OUT (br1)
`ifdef SERSUB_SIGNED_OVF_EN
    ,
    .OVF    (ovf1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=8 operation started from IDLE. With noise set, START is held
  // high with other operands during the first three busy cycles and in FIN.
  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic bi, input bit noise);
    int         diff;
    int         sdiff;
    logic [7:0] e_dif;
    logic       e_br;
    logic       e_ovf;
    bit         busy_ok;
    bit         stable_ok;
    int         dones;

    diff  = int'(a) - int'(b) - int'(bi);
    e_dif = 8'(diff);
    e_br  = (diff < 0);
    sdiff = int'($signed(a)) - int'($signed(b)) - int'(bi);
    e_ovf = (sdiff < -128) || (sdiff > 127);

    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b; bi8 = bi;
    busy_ok = 1'b1; stable_ok = 1'b1; dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (noise && i < 3) begin
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; bi8 = 1'b0;
      end else begin
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      end
      if (busy8 !== 1'b1) busy_ok = 1'b0;
      if (done8 === 1'b1) dones++;
      if (dif8 !== last_dif || br8 !== last_br) stable_ok = 1'b0;
    end
    @(negedge clk);
    chk("op8_busy_window", 32'(busy_ok), 32'd1);
    chk("op8_no_early_done", 32'(dones), 32'd0);
    chk("op8_result_held_while_busy", 32'(stable_ok), 32'd1);
    chk("op8_done_pulse", 32'(done8), 32'd1);
    chk("op8_busy_low_in_fin", 32'(busy8), 32'd0);
    chk("op8_dif", 32'(dif8), 32'(e_dif));
    chk("op8_br_out", 32'(br8), 32'(e_br));
`ifdef SERSUB_SIGNED_OVF_EN
    chk("op8_ovf", 32'(ovf8), 32'(e_ovf));
`endif
    if (noise) start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    chk("op8_done_one_cycle", 32'(done8), 32'd0);
    chk("op8_idle_after_fin", 32'(busy8), 32'd0);
    last_dif = e_dif;
    last_br  = e_br;
  endtask

  task automatic do_op1(input logic a, input logic b, input logic bi);
    int diff;
    diff = int'(a) - int'(b) - int'(bi);
    @(negedge clk);
    start1 = 1'b1; a1 = a; b1 = b; bi1 = bi;
    @(negedge clk);
    start1 = 1'b0;
    chk("op1_busy", 32'(busy1), 32'd1);
    chk("op1_done_not_yet", 32'(done1), 32'd0);
    @(negedge clk);
    chk("op1_done", 32'(done1), 32'd1);
    chk("op1_dif", 32'(dif1), 32'(diff & 1));
    chk("op1_br_out", 32'(br1), 32'(diff < 0));
    @(negedge clk);
    chk("op1_done_cleared", 32'(done1), 32'd0);
  endtask

  initial begin
    int dones;
    rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; bi8 = 1'b0;
    rst1 = 1'b1; start1 = 1'b0; a1 = '0; b1 = '0; bi1 = 1'b0;
    last_dif = 8'h00; last_br = 1'b0;
    repeat (3) @(negedge clk);
    rst8 = 1'b0; rst1 = 1'b0;
    chk("rst_busy8", 32'(busy8), 32'd0);
    chk("rst_done8", 32'(done8), 32'd0);
    chk("rst_dif8", 32'(dif8), 32'd0);
    chk("rst_br8", 32'(br8), 32'd0);
    chk("rst_busy1", 32'(busy1), 32'd0);
    chk("rst_dif1", 32'(dif1), 32'd0);

    // Directed vectors.
    do_op8(8'h5A, 8'h3C, 1'b0, 1'b0);
    do_op8(8'h00, 8'h01, 1'b0, 1'b0);
    do_op8(8'h10, 8'h0F, 1'b1, 1'b0);
    do_op8(8'h80, 8'h01, 1'b0, 1'b0);
    do_op8(8'h05, 8'h03, 1'b0, 1'b0);
    do_op8(8'h00, 8'hFF, 1'b1, 1'b0);
    do_op8(8'hFF, 8'hFF, 1'b0, 1'b0);

    // START during BUSY and FIN must be ignored.
    do_op8(8'h37, 8'h52, 1'b1, 1'b1);

    // Reset in the 4th SHIFT cycle aborts the operation.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h33; b8 = 8'h11; bi8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_in_shift", 32'(busy8), 32'd1);
    rst8 = 1'b1;
    @(negedge clk);
    rst8 = 1'b0;
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_done", 32'(done8), 32'd0);
    chk("abort_dif", 32'(dif8), 32'd0);
    chk("abort_br", 32'(br8), 32'd0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8 === 1'b1 || busy8 === 1'b1) dones++;
    end
    chk("abort_no_late_done", 32'(dones), 32'd0);
    last_dif = 8'h00; last_br = 1'b0;
    do_op8(8'h09, 8'h04, 1'b0, 1'b0);

    // Random operands.
    for (int i = 0; i < 24; i++) begin
      do_op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    // WIDTH=1 exhaustive truth table.
    for (int v = 0; v < 8; v++) begin
      logic [2:0] vv;
      vv = 3'(v);
      do_op1(vv[2], vv[1], vv[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
